// File: rtl/shift_sequencer.sv
// Multicycle shift controller: latches an operand and shift amount, then shifts one bit per cycle.
// Reports busy while working and pulses done for one cycle when the result is final.
module shift_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        shift_op,
    input  logic [1:0]        shift_n_ctrl,
    input  logic [DATA_W-1:0] data_in,
    input  logic [31:0]       B,
    input  logic [31:0]       MemDataOut,
    input  logic [15:0]       Instruction_15_0,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [N_W-1:0]    shamt_out
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    state_e            r_state, w_state_next;
    logic [DATA_W-1:0] r_result, w_result_next, w_shifted;
    logic [1:0]        r_op, w_op_next;
    logic [N_W-1:0]    r_count, w_count_next;
    logic [N_W-1:0]    r_shamt, w_shamt_next;
    logic [N_W-1:0]    w_n_sel;

    always_comb begin
        case (shift_n_ctrl)
            2'b00:   w_n_sel = B[N_W-1:0];
            2'b01:   w_n_sel = MemDataOut[N_W-1:0];
            default: w_n_sel = N_W'(Instruction_15_0[10:6]);
        endcase
    end

    always_comb begin
        case (r_op)
            2'b00:   w_shifted = {r_result[DATA_W-2:0], 1'b0};
            2'b01:   w_shifted = {1'b0, r_result[DATA_W-1:1]};
            2'b10:   w_shifted = {r_result[DATA_W-1], r_result[DATA_W-1:1]};
            default: w_shifted = {r_result[0], r_result[DATA_W-1:1]};
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        w_op_next     = r_op;
        w_count_next  = r_count;
        w_shamt_next  = r_shamt;
        case (r_state)
            StIdle: begin
                // flush outranks start so an aborting controller cannot launch a new op
                if (start && !flush) begin
                    w_result_next = data_in;
                    w_op_next     = shift_op;
                    w_count_next  = w_n_sel;
                    w_shamt_next  = w_n_sel;
                    w_state_next  = (w_n_sel == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (flush) begin
                    w_state_next = StIdle;
                end else begin
                    w_result_next = w_shifted;
                    w_count_next  = r_count - 1'b1;
                    if (r_count == N_W'(1)) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_op     <= '0;
            r_count  <= '0;
            r_shamt  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_result <= w_result_next;
            r_op     <= w_op_next;
            r_count  <= w_count_next;
            r_shamt  <= w_shamt_next;
        end
    end

    assign busy      = (r_state != StIdle);
    assign done      = (r_state == StDone);
    assign result    = r_result;
    assign shamt_out = r_shamt;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes expected results, a monitor checks each done.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  shift_op, shift_n_ctrl;
    logic [31:0] data_in, B, MemDataOut;
    logic [15:0] Instruction_15_0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  shamt_out;

    shift_sequencer #(.DATA_W(32), .N_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .shift_op         (shift_op),
        .shift_n_ctrl     (shift_n_ctrl),
        .data_in          (data_in),
        .B                (B),
        .MemDataOut       (MemDataOut),
        .Instruction_15_0 (Instruction_15_0),
        .flush            (flush),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .shamt_out        (shamt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  sh;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [4:0] sel_n(input logic [1:0] ctrl, input logic [31:0] b,
                                         input logic [31:0] m, input logic [15:0] ins);
        if (ctrl == 2'b00) return b[4:0];
        if (ctrl == 2'b01) return m[4:0];
        return ins[10:6];
    endfunction

    // Closed-form reference: whole shift in one expression
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input int n);
        case (op)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return $signed(d) >>> n;
            default: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("shamt_out", {27'd0, shamt_out}, {27'd0, e.sh});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [1:0] ctrl, input logic [31:0] b,
                          input logic [31:0] m, input logic [15:0] ins, input logic [31:0] d,
                          input bit noise);
        int   n;
        bit   busy_ok;
        exp_t e;
        @(negedge clk);
        shift_op = op; shift_n_ctrl = ctrl; B = b; MemDataOut = m;
        Instruction_15_0 = ins; data_in = d; start = 1'b1; flush = 1'b0;
        n = int'(sel_n(ctrl, b, m, ins));
        e.res = ref_shift(op, d, n);
        e.sh  = 5'(n);
        e.cyc = cyc + 1 + n;
        exp_q.push_back(e);
        busy_ok = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (noise && i < n) begin
                start = 1'($urandom); data_in = $urandom; B = $urandom;
                MemDataOut = $urandom; Instruction_15_0 = 16'($urandom);
                shift_op = 2'($urandom); shift_n_ctrl = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("busy_during_op", {31'd0, busy_ok}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b0; start = 1'b0; flush = 1'b0; shift_op = 2'b00; shift_n_ctrl = 2'b00;
        data_in = '0; B = '0; MemDataOut = '0; Instruction_15_0 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_shamt", {27'd0, shamt_out}, 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;

        // directed cases
        run_op(2'b00, 2'b10, 32'h0, 32'h0, 16'(4 << 6), 32'h0000_00F1, 1'b0);
        run_op(2'b10, 2'b00, 32'd8, 32'h0, 16'h0, 32'h8000_1234, 1'b0);
        run_op(2'b01, 2'b00, 32'd8, 32'h0, 16'h0, 32'h8000_1234, 1'b0);
        run_op(2'b11, 2'b01, 32'h0, 32'd31, 16'h0, 32'h0000_0001, 1'b0);
        run_op(2'b00, 2'b00, 32'hFFFF_FFE0, 32'h0, 16'h0, 32'hDEAD_BEEF, 1'b0);
        run_op(2'b10, 2'b11, 32'h0, 32'h0, 16'(7 << 6), 32'h9ABC_DEF0, 1'b1);

        // flush in cycle 3 of an N=10 sll: two shifts done, no done pulse
        d = 32'h0000_0A5B;
        @(negedge clk);
        shift_op = 2'b00; shift_n_ctrl = 2'b00; B = 32'd10; data_in = d; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_idle", {31'd0, busy}, 32'd0);
        chk("flush_partial", result, d << 2);
        repeat (12) @(negedge clk);
        // flush outranks start in IDLE
        flush = 1'b1; start = 1'b1; B = 32'd5; data_in = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_blocks_start", {31'd0, busy}, 32'd0);
        end
        chk("flush_keeps_result", result, d << 2);
        flush = 1'b0; start = 1'b0;

        // reset during an N=20 op
        @(negedge clk);
        shift_op = 2'b01; shift_n_ctrl = 2'b10; Instruction_15_0 = 16'(20 << 6);
        data_in = 32'hF0F0_F0F0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_shamt", {27'd0, shamt_out}, 32'd0);
        reset = 1'b1;
        run_op(2'b00, 2'b10, 32'h0, 32'h0, 16'(3 << 6), 32'h0000_0011, 1'b0);

        // randomized traffic with input noise while busy
        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom), 2'($urandom), $urandom, $urandom, 16'($urandom), $urandom,
                   1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
